// File: rtl/network_interface.sv
// Local-port network interface between a core and its mesh router.
// Buffers packets in both directions and keeps traffic counters and sticky error flags.
package network_interface_pkg;
  typedef struct packed {
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [23:0] payload;
  } packet_t;
endpackage

// Circular buffer with an occupancy counter and a registered "room available" enable.
module network_interface_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       en
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!push && pop) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      en     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
      en  <= (cnt_nxt < FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Head is forced to zero when empty so stale storage never reaches the outputs.
  assign rd_data = (cnt == '0) ? '0 : mem[rd_ptr];
endmodule

module network_interface
  import network_interface_pkg::*;
#(
  parameter int X_LOC    = 0,
  parameter int Y_LOC    = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  packet_t          i_core_data,
  input  logic             i_core_val,
  output logic             o_core_en,
  output packet_t          o_rtr_data,
  output logic             o_rtr_val,
  input  logic             i_rtr_en,
  input  packet_t          i_rtr_data,
  input  logic             i_rtr_val,
  output logic             o_rtr_en,
  output packet_t          o_core_data,
  output logic             o_core_val,
  input  logic             i_core_en,
  output logic [CNT_W-1:0] o_tx_count,
  output logic [CNT_W-1:0] o_rx_count,
  output logic             o_misroute,
  output logic             o_rx_overflow
);
  localparam int PW = $bits(packet_t);
  localparam logic [3:0] X_ADDR = 4'(X_LOC);
  localparam logic [3:0] Y_ADDR = 4'(Y_LOC);
  localparam logic [$clog2(RX_DEPTH):0] RX_FULL = ($clog2(RX_DEPTH)+1)'(RX_DEPTH);

  logic [$clog2(TX_DEPTH):0] tx_cnt;
  logic [$clog2(RX_DEPTH):0] rx_cnt;
  logic [PW-1:0]             tx_head, rx_head;
  logic                      tx_push, rx_push, rx_full;

  // A core packet offered while o_core_en is low is a protocol violation and is ignored.
  assign tx_push   = i_core_val && o_core_en;
  assign o_rtr_val = (tx_cnt != '0) && i_rtr_en;
  assign o_rtr_data = packet_t'(tx_head);

  assign rx_full    = (rx_cnt == RX_FULL);
  assign rx_push    = i_rtr_val && !rx_full;
  assign o_core_val = (rx_cnt != '0) && i_core_en;
  assign o_core_data = packet_t'(rx_head);

  network_interface_fifo #(.DEPTH(TX_DEPTH), .W(PW)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (o_rtr_val),
    .wr_data (i_core_data),
    .rd_data (tx_head),
    .cnt     (tx_cnt),
    .en      (o_core_en)
  );

  network_interface_fifo #(.DEPTH(RX_DEPTH), .W(PW)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (o_core_val),
    .wr_data (i_rtr_data),
    .rd_data (rx_head),
    .cnt     (rx_cnt),
    .en      (o_rtr_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tx_count    <= '0;
      o_rx_count    <= '0;
      o_misroute    <= 1'b0;
      o_rx_overflow <= 1'b0;
    end else begin
      if (o_rtr_val) o_tx_count <= o_tx_count + CNT_W'(1);
      if (rx_push) begin
        o_rx_count <= o_rx_count + CNT_W'(1);
        if (i_rtr_data.x_dest != X_ADDR || i_rtr_data.y_dest != Y_ADDR)
          o_misroute <= 1'b1;
      end
      if (i_rtr_val && rx_full) o_rx_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface: expected packets are queued when driven
// and compared in order as the DUT presents them on either output link.
module tb_network_interface;
  import network_interface_pkg::*;

  localparam int X  = 2;
  localparam int Y  = 1;
  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  packet_t       i_core_data, o_rtr_data, i_rtr_data, o_core_data;
  logic          i_core_val, o_core_en, o_rtr_val, i_rtr_en;
  logic          i_rtr_val, o_rtr_en, o_core_val, i_core_en;
  logic [CW-1:0] o_tx_count, o_rx_count;
  logic          o_misroute, o_rx_overflow;

  network_interface #(
    .X_LOC(X), .Y_LOC(Y), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_W(CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_core_data   (i_core_data),
    .i_core_val    (i_core_val),
    .o_core_en     (o_core_en),
    .o_rtr_data    (o_rtr_data),
    .o_rtr_val     (o_rtr_val),
    .i_rtr_en      (i_rtr_en),
    .i_rtr_data    (i_rtr_data),
    .i_rtr_val     (i_rtr_val),
    .o_rtr_en      (o_rtr_en),
    .o_core_data   (o_core_data),
    .o_core_val    (o_core_val),
    .i_core_en     (i_core_en),
    .o_tx_count    (o_tx_count),
    .o_rx_count    (o_rx_count),
    .o_misroute    (o_misroute),
    .o_rx_overflow (o_rx_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_tx = 0;
  int exp_rx = 0;
  packet_t tx_q[$];
  packet_t rx_q[$];
  packet_t tx_exp, rx_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic packet_t mk(input int x, input int y, input int pl);
    packet_t p;
    p.x_dest  = 4'(x);
    p.y_dest  = 4'(y);
    p.payload = 24'(pl);
    return p;
  endfunction

  // Outputs are sampled on the falling edge; a valid seen here transfers on the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_rtr_val) begin
        chk("tx_avail", 64'(tx_q.size() != 0), 64'd1);
        if (tx_q.size() != 0) begin
          tx_exp = tx_q.pop_front();
          chk("tx_data", 64'(o_rtr_data), 64'(tx_exp));
        end
      end
      if (o_core_val) begin
        chk("rx_avail", 64'(rx_q.size() != 0), 64'd1);
        if (rx_q.size() != 0) begin
          rx_exp = rx_q.pop_front();
          chk("rx_data", 64'(o_core_data), 64'(rx_exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_core(input packet_t p, input bit accept);
    i_core_data = p;
    i_core_val  = 1'b1;
    if (accept) begin
      tx_q.push_back(p);
      exp_tx++;
    end
    tick();
  endtask

  task automatic send_rtr(input packet_t p, input bit accept);
    i_rtr_data = p;
    i_rtr_val  = 1'b1;
    if (accept) begin
      rx_q.push_back(p);
      exp_rx++;
    end
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    i_core_data = '0; i_core_val = 1'b0; i_rtr_en = 1'b0;
    i_rtr_data = '0;  i_rtr_val = 1'b0;  i_core_en = 1'b0;

    // reset state
    #2;
    chk("rst_core_en", 64'(o_core_en), 64'd0);
    chk("rst_rtr_en",  64'(o_rtr_en), 64'd0);
    chk("rst_vals",    64'({o_rtr_val, o_core_val}), 64'd0);
    chk("rst_data",    64'({o_rtr_data, o_core_data}), 64'd0);
    chk("rst_counts",  64'({o_tx_count, o_rx_count}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("pre_edge_core_en", 64'(o_core_en), 64'd0);
    tick();
    chk("post_edge_core_en", 64'(o_core_en), 64'd1);
    chk("post_edge_rtr_en",  64'(o_rtr_en), 64'd1);

    // three back-to-back core packets, router accepting
    i_rtr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_core_data = mk(5, 6, 16 + k);
      if (k == 0) chk("no_fallthrough", 64'(o_rtr_val), 64'd0);
      send_core(mk(5, 6, 16 + k), 1'b1);
      chk("tx_val_stream", 64'(o_rtr_val), 64'd1);
    end
    i_core_val = 1'b0;
    tick();
    chk("tx_val_idle", 64'(o_rtr_val), 64'd0);
    chk("tx_count_3", 64'(o_tx_count), 64'(exp_tx));

    // fill TX with router stalled; fifth packet is refused
    i_rtr_en = 1'b0;
    for (int k = 0; k < TXD + 1; k++) begin
      send_core(mk(7, 3, 32 + k), k < TXD);
      chk("core_en_fill", 64'(o_core_en), 64'(k < TXD - 1));
    end
    i_core_val = 1'b0;
    chk("tx_stalled", 64'(o_rtr_val), 64'd0);
    chk("tx_count_stall", 64'(o_tx_count), 64'd3);
    i_rtr_en = 1'b1;
    #1;
    chk("core_en_full_pop", 64'(o_core_en), 64'd0);
    tick();
    chk("core_en_reassert", 64'(o_core_en), 64'd1);
    repeat (4) tick();
    chk("tx_drained", 64'(o_rtr_val), 64'd0);
    chk("tx_count_7", 64'(o_tx_count), 64'(exp_tx));
    chk("tx_q_empty", 64'(tx_q.size()), 64'd0);

    // two correctly addressed router packets held, then released to core
    i_core_en = 1'b0;
    send_rtr(mk(X, Y, 100), 1'b1);
    send_rtr(mk(X, Y, 101), 1'b1);
    i_rtr_val = 1'b0;
    chk("rx_held", 64'(o_core_val), 64'd0);
    chk("rx_count_2", 64'(o_rx_count), 64'(exp_rx));
    i_core_en = 1'b1;
    repeat (3) tick();
    chk("rx_q_empty", 64'(rx_q.size()), 64'd0);
    chk("misroute_clean", 64'(o_misroute), 64'd0);

    // misrouted packet is flagged and still delivered
    send_rtr(mk(X + 1, Y, 200), 1'b1);
    i_rtr_val = 1'b0;
    repeat (2) tick();
    chk("misroute_set", 64'(o_misroute), 64'd1);
    chk("misroute_delivered", 64'(rx_q.size()), 64'd0);
    chk("rx_count_3", 64'(o_rx_count), 64'(exp_rx));

    // fill RX, then force one more packet in
    i_core_en = 1'b0;
    for (int k = 0; k < RXD; k++) send_rtr(mk(X, Y, 300 + k), 1'b1);
    chk("rtr_en_full", 64'(o_rtr_en), 64'd0);
    chk("overflow_clear", 64'(o_rx_overflow), 64'd0);
    send_rtr(mk(X, Y, 399), 1'b0);
    i_rtr_val = 1'b0;
    chk("overflow_set", 64'(o_rx_overflow), 64'd1);
    chk("rx_count_ovf", 64'(o_rx_count), 64'(exp_rx));
    chk("misroute_sticky", 64'(o_misroute), 64'd1);

    // buffer some TX traffic, then reset in the middle of a cycle
    i_rtr_en = 1'b0;
    send_core(mk(1, 1, 500), 1'b1);
    send_core(mk(1, 1, 501), 1'b1);
    i_core_val = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    tx_q.delete();
    rx_q.delete();
    exp_tx = 0;
    exp_rx = 0;
    i_core_en = 1'b1;
    i_rtr_en  = 1'b1;
    #1;
    chk("mid_rst_vals",   64'({o_rtr_val, o_core_val}), 64'd0);
    chk("mid_rst_ens",    64'({o_core_en, o_rtr_en}), 64'd0);
    chk("mid_rst_counts", 64'({o_tx_count, o_rx_count}), 64'd0);
    chk("mid_rst_flags",  64'({o_misroute, o_rx_overflow}), 64'd0);
    chk("mid_rst_data",   64'({o_rtr_data, o_core_data}), 64'd0);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_core_en", 64'(o_core_en), 64'd1);
    chk("post_rst_empty",   64'({o_rtr_val, o_core_val}), 64'd0);
    send_core(mk(4, 4, 600), 1'b1);
    i_core_val = 1'b0;
    repeat (2) tick();
    chk("post_rst_tx_count", 64'(o_tx_count), 64'(exp_tx));
    chk("post_rst_tx_q", 64'(tx_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
